// File: rtl/aabb_slab_reducer_pkg.sv
// Shared definitions for the ray/AABB slab reduction stage: FP word layout,
// exception codes, FSM state and comparison step encodings.
package raabb_pkg;

  localparam int FP_W = 21;

  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  localparam logic [FP_W-1:0] FP_ZERO = {EXC_ZERO, {(FP_W-2){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    STEP_NEAR_XY  = 3'd0,
    STEP_NEAR_Z   = 3'd1,
    STEP_FAR_XY   = 3'd2,
    STEP_FAR_Z    = 3'd3,
    STEP_OVERLAP  = 3'd4,
    STEP_POSITIVE = 3'd5
  } step_t;

  function automatic logic exc_is_nan(input logic [1:0] exc);
    return exc == EXC_NAN;
  endfunction

  // Strictly negative: negative zero does not count.
  function automatic logic fp_is_neg(input logic [1:0] exc, input logic sign);
    return sign && ((exc == EXC_NORMAL) || (exc == EXC_INF));
  endfunction

endpackage

// File: rtl/aabb_slab_reducer.sv
// Reduces six slab distances to tNear/tFar and a hit flag using one shared
// external comparator. Define AABB_EARLY_EXIT_EN to skip the last two steps when tFar < 0.
module aabb_slab_reducer
  import raabb_pkg::*;
#(
  parameter int width   = 20,
  parameter int CMP_LAT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [width:0] tnear_x,
  input  logic [width:0] tnear_y,
  input  logic [width:0] tnear_z,
  input  logic [width:0] tfar_x,
  input  logic [width:0] tfar_y,
  input  logic [width:0] tfar_z,
  output logic [width:0] cmp_a,
  output logic [width:0] cmp_b,
  input  logic           cmp_ge,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           hit,
  output logic [width:0] t_near,
  output logic [width:0] t_far
);

  localparam int CNT_W = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMP_LAT - 1);

  typedef logic [width:0] word_t;

  state_t           state_q, state_d;
  step_t            step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  word_t            nx_q, nx_d, ny_q, ny_d, nz_q, nz_d;
  word_t            fx_q, fx_d, fy_q, fy_d, fz_q, fz_d;
  word_t            tn_q, tn_d, tf_q, tf_d;
  logic             g1_q, g1_d, g2_q, g2_d, nan_q, nan_d;

  word_t            op_a, op_b;
  logic             any_nan;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= STEP_NEAR_XY;
      cnt_q   <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
      nz_q    <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      fz_q    <= '0;
      tn_q    <= '0;
      tf_q    <= '0;
      g1_q    <= 1'b0;
      g2_q    <= 1'b0;
      nan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      nz_q    <= nz_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      fz_q    <= fz_d;
      tn_q    <= tn_d;
      tf_q    <= tf_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      nan_q   <= nan_d;
    end
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (step_q)
      STEP_NEAR_XY:  begin op_a = ny_q; op_b = nx_q; end
      STEP_NEAR_Z:   begin op_a = nz_q; op_b = tn_q; end
      STEP_FAR_XY:   begin op_a = fy_q; op_b = fx_q; end
      STEP_FAR_Z:    begin op_a = fz_q; op_b = tf_q; end
      STEP_OVERLAP:  begin op_a = tf_q; op_b = tn_q; end
      STEP_POSITIVE: begin op_a = tf_q; op_b = word_t'(FP_ZERO); end
      default:       begin op_a = '0;   op_b = '0;   end
    endcase
  end

  always_comb begin
    any_nan = exc_is_nan(tnear_x[width:width-1]) | exc_is_nan(tnear_y[width:width-1]) |
              exc_is_nan(tnear_z[width:width-1]) | exc_is_nan(tfar_x[width:width-1])  |
              exc_is_nan(tfar_y[width:width-1])  | exc_is_nan(tfar_z[width:width-1]);
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    nz_d    = nz_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    fz_d    = fz_q;
    tn_d    = tn_q;
    tf_d    = tf_q;
    g1_d    = g1_q;
    g2_d    = g2_q;
    nan_d   = nan_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          nx_d    = tnear_x;
          ny_d    = tnear_y;
          nz_d    = tnear_z;
          fx_d    = tfar_x;
          fy_d    = tfar_y;
          fz_d    = tfar_z;
          nan_d   = any_nan;
          g1_d    = 1'b0;
          g2_d    = 1'b0;
          step_d  = STEP_NEAR_XY;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          case (step_q)
            STEP_NEAR_XY:  tn_d = cmp_ge ? ny_q : nx_q;
            STEP_NEAR_Z:   tn_d = cmp_ge ? nz_q : tn_q;
            STEP_FAR_XY:   tf_d = cmp_ge ? fx_q : fy_q;
            STEP_FAR_Z:    tf_d = cmp_ge ? tf_q : fz_q;
            STEP_OVERLAP:  g1_d = cmp_ge;
            STEP_POSITIVE: g2_d = cmp_ge;
            default:       ;
          endcase
          if (step_q == STEP_POSITIVE) begin
            state_d = ST_DONE;
          end else begin
            step_d  = step_t'(step_q + 3'd1);
            state_d = ST_ISSUE;
          end
`ifdef AABB_EARLY_EXIT_EN
          // Uses the freshly reduced tf, so the decision lands in the same cycle as step 3.
          if ((step_q == STEP_FAR_Z) && fp_is_neg(tf_d[width:width-1], tf_d[width-2])) begin
            g1_d    = 1'b0;
            state_d = ST_DONE;
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
      cmp_a = op_a;
      cmp_b = op_b;
    end else begin
      cmp_a = '0;
      cmp_b = '0;
    end
    if (state_q == ST_DONE) begin
      hit    = g1_q & g2_q & ~nan_q;
      t_near = tn_q;
      t_far  = tf_q;
    end else begin
      hit    = 1'b0;
      t_near = '0;
      t_far  = '0;
    end
  end

endmodule

// File: tb/tb_aabb_slab_reducer.sv
// Directed bench for aabb_slab_reducer with a behavioural 3-cycle FP >= comparator.
module tb_aabb_slab_reducer;

  localparam logic [20:0] ONE   = 21'h09FF80;
  localparam logic [20:0] TWO   = 21'h0A0000;
  localparam logic [20:0] THREE = 21'h0A0040;
  localparam logic [20:0] MONE  = 21'h0DFF80;
  localparam logic [20:0] QNAN  = 21'h180000;
  localparam logic [20:0] ZERO  = 21'h000000;

`ifdef AABB_EARLY_EXIT_EN
  localparam int NEG_LAT = 17;
`else
  localparam int NEG_LAT = 25;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, hit;
  logic        cmp_ge = 1'b0;
  logic        p1 = 1'b0, p2 = 1'b0;
  logic [20:0] nx = '0, ny = '0, nz = '0, fx = '0, fy = '0, fz = '0;
  logic [20:0] cmp_a, cmp_b, t_near, t_far;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aabb_slab_reducer #(.width(20), .CMP_LAT(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .tnear_x(nx), .tnear_y(ny), .tnear_z(nz),
    .tfar_x(fx), .tfar_y(fy), .tfar_z(fz),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_ge(cmp_ge),
    .out_valid(out_valid), .out_ready(out_ready),
    .hit(hit), .t_near(t_near), .t_far(t_far)
  );

  function automatic logic signed [21:0] fp_key(input logic [20:0] v);
    logic [20:0] mag;
    mag = (v[20:19] == 2'b00) ? 21'd0 : {v[20:19], v[17:0]};
    return v[18] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  function automatic logic fp_ge(input logic [20:0] a, input logic [20:0] b);
    if ((a[20:19] == 2'b11) || (b[20:19] == 2'b11)) return 1'b0;
    return fp_key(a) >= fp_key(b);
  endfunction

  // Comparator model: result valid 3 cycles after operands become stable.
  always @(posedge clk) begin
    p1     <= fp_ge(cmp_a, cmp_b);
    p2     <= p1;
    cmp_ge <= p2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [20:0] a, input logic [20:0] b, input logic [20:0] c,
                      input logic [20:0] d, input logic [20:0] e, input logic [20:0] f);
    nx = a; ny = b; nz = c; fx = d; fy = e; fz = f;
    in_valid = 1'b1;
    chk("accept_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("step0_cmp_a", cmp_a, b);
    chk("step0_cmp_b", cmp_b, a);
  endtask

  task automatic wait_out(input string tag, input int start, input int exp_lat);
    int lat;
    lat = start;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk(tag, lat, exp_lat);
  endtask

  task automatic take(input logic hit_e, input logic [20:0] tn_e, input logic [20:0] tf_e);
    chk("res_hit", hit, hit_e);
    chk("res_t_near", t_near, tn_e);
    chk("res_t_far", t_far, tf_e);
    @(negedge clk);
    chk("consumed_out_valid", out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_hit", hit, 0);
    chk("rst_t_near", t_near, 0);
    chk("rst_t_far", t_far, 0);
    chk("rst_cmp_a", cmp_a, 0);
    chk("rst_cmp_b", cmp_b, 0);

    // 1: overlapping slabs
    send(ONE, TWO, MONE, THREE, THREE, TWO);
    repeat (4) @(negedge clk);
    chk("s1_step1_cmp_a", cmp_a, MONE);
    chk("s1_step1_cmp_b", cmp_b, TWO);
    wait_out("s1_latency", 5, 25);
    take(1'b1, TWO, TWO);

    // 2: tFar < tNear
    send(TWO, ONE, ZERO, ONE, THREE, THREE);
    wait_out("s2_latency", 1, 25);
    take(1'b0, TWO, ONE);

    // 3: box behind the ray
    send(ONE, ONE, ONE, MONE, MONE, MONE);
    wait_out("s3_latency", 1, NEG_LAT);
    chk("s3_hit", hit, 0);
    chk("s3_t_far", t_far, MONE);
    @(negedge clk);

    // 4: NaN input
    send(QNAN, TWO, MONE, THREE, THREE, TWO);
    wait_out("s4_latency", 1, 25);
    chk("s4_hit", hit, 0);
    @(negedge clk);

    // 5: back-pressure with in_valid held high
    nx = ONE; ny = TWO; nz = MONE; fx = THREE; fy = THREE; fz = TWO;
    in_valid = 1'b1;
    out_ready = 1'b0;
    chk("s5_in_ready", in_ready, 1);
    @(negedge clk);
    wait_out("s5_latency", 1, 25);
    for (int i = 0; i < 10; i++) begin
      chk("s5_hold_valid", out_valid, 1);
      chk("s5_hold_hit", hit, 1);
      chk("s5_hold_t_near", t_near, TWO);
      chk("s5_hold_t_far", t_far, TWO);
      chk("s5_hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("s5_idle_in_ready", in_ready, 1);
    chk("s5_idle_out_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("s5_reaccept_in_ready", in_ready, 0);
    chk("s5_reaccept_cmp_a", cmp_a, TWO);
    wait_out("s5b_latency", 1, 25);
    take(1'b1, TWO, TWO);

    // 6: reset mid-sequence
    send(ONE, TWO, MONE, THREE, THREE, TWO);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s6_in_ready", in_ready, 1);
    chk("s6_out_valid", out_valid, 0);
    chk("s6_cmp_a", cmp_a, 0);
    chk("s6_cmp_b", cmp_b, 0);
    send(TWO, ONE, ZERO, ONE, THREE, THREE);
    wait_out("s6_latency", 1, 25);
    take(1'b0, TWO, ONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
